transpose_buf: RTL and testbench
================================

TRANSPOSE_BUF -- requirements
Module: transpose_buf

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  upstream row word valid.
REQ-004 in_ready  output  1  block can accept a row this cycle.
REQ-005 in_data  input  64  one 8-pixel row from the 1-D row stage; byte k = bits[8k+7:8k].
REQ-006 out_valid  output  1  column word available.
REQ-007 out_ready  input  1  downstream (column 1-D stage) accepts the column.
REQ-008 out_data  output  64  one 8-pixel column; byte r = bits[8r+7:8r] = byte j of stored row r, where j is the current column index.
REQ-009 out_last  output  1  high with out_valid while column 7 of a block is presented.

Function
REQ-010 A row transfers on a cycle with in_valid && in_ready; a column transfers on a cycle with out_valid && out_ready.
REQ-011 Rows SHALL be written in arrival order to row index 0..7 of the write bank; the row counter wraps 7->0 after each write.
REQ-012 The 8th row transfer SHALL mark the write bank FULL; out_valid rises on the next cycle (latency: 1 cycle from the 8th row handshake to the first column).
REQ-013 Columns SHALL be presented in order j = 0..7; the column counter advances only on a column transfer and wraps 7->0.
REQ-014 The column-7 transfer SHALL clear the read bank's FULL flag; out_valid falls on the next cycle unless the other bank is FULL.
REQ-015 out_data, out_valid and out_last SHALL hold stable while out_valid && !out_ready.
REQ-016 in_ready SHALL equal NOT FULL of the current write bank; in_data is ignored when in_ready is low.
REQ-017 Each bank SHALL cycle EMPTY -> FILLING (first row written) -> FULL (8th row) -> DRAINING (first column read) -> EMPTY (column 7 read).
REQ-018 When a write-complete and a read-complete occur in the same cycle, both flag updates SHALL take effect; neither is lost.
REQ-019 No arithmetic is performed; pixel bytes pass through unchanged, 8 bits each.

Reset
REQ-020 Asserting rst_n low SHALL immediately clear all FULL flags, row/column counters and bank pointers, and zero all storage.
REQ-021 During and after reset: out_valid=0, out_last=0, out_data=0, in_ready=1.
REQ-022 Reset asserted mid-block SHALL discard any partial or undrained block; the next row after release is written to row 0 of bank 0.

Configuration
REQ-023 Macro TRANSPOSE_PINGPONG_EN selects double buffering.
REQ-024 With TRANSPOSE_PINGPONG_EN defined: two banks; write and read pointers toggle independently on block completion; writing of block N+1 overlaps draining of block N; sustained throughput of 1 word/cycle on both sides.
REQ-025 Without TRANSPOSE_PINGPONG_EN: one bank; in_ready is low from the 8th row transfer until the column-7 transfer; at least 8 idle input cycles per block.

Structure
REQ-026 Shared package dwt_pkg SHALL hold PIX_W=8, BLK_N=8, ROW_W=64 and the bank state enumeration.
REQ-027 One sub-module, transpose_bank, SHALL implement a single 8x8-byte storage bank with row write port and column read mux; transpose_buf instantiates one or two of them.

Verification
REQ-028 Row r = {8{r+1 as byte}} for r=0..7, out_ready=1 -> every column equals 0x0807060504030201, out_last on the 8th column.
REQ-029 Row r byte k = 8r+k -> column j byte r = 8r+j (column 0 = 0x3830282018100800).
REQ-030 out_ready held low 5 cycles at column 3 -> out_data, out_valid, out_last unchanged for those cycles; column 4 follows release.
REQ-031 PINGPONG_EN, two back-to-back blocks, both sides always ready -> in_ready never drops, 16 columns out with no gap after the first; without the macro -> in_ready low for exactly 8 cycles between blocks.
REQ-032 rst_n pulsed low after 5 rows of a block -> out_valid stays 0; a fresh 8-row block then emits correct columns from bank 0.

Source files
------------

// File: rtl/dwt_pkg.sv
// dwt_pkg: shared pixel/block constants and bank state encoding; bank count follows TRANSPOSE_PINGPONG_EN
package dwt_pkg;
   localparam int PIX_W = 8;
   localparam int BLK_N = 8;
   localparam int ROW_W = PIX_W * BLK_N;
   localparam int IDX_W = $clog2(BLK_N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_N - 1);
`ifdef TRANSPOSE_PINGPONG_EN
   localparam int BANK_N = 2;
`else
   localparam int BANK_N = 1;
`endif
   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_st_e;
   function automatic logic is_full(bank_st_e s);
      return (s == BANK_FULL) || (s == BANK_DRAINING);
   endfunction
endpackage

// File: rtl/transpose_buf_if.sv
// transpose_buf_if: row-in / column-out valid-ready streams of the transpose buffer
interface transpose_buf_if;
   import dwt_pkg::*;
   logic             in_valid;
   logic             in_ready;
   logic [ROW_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [ROW_W-1:0] out_data;
   logic             out_last;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/transpose_bank.sv
// transpose_bank: one 8x8-byte bank with row write port, column read mux and EMPTY/FILLING/FULL/DRAINING tracking
module transpose_bank import dwt_pkg::*; (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_row,
   input  logic [ROW_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_col,
   output logic [ROW_W-1:0] rd_data,
   output logic             full
);
   bank_st_e st, st_nxt;
   logic [BLK_N-1:0][ROW_W-1:0] mem;
   // row storage, cleared on reset so outputs read back as zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mem <= '0;
      else if (wr_en) mem[wr_row] <= wr_data;
   // column j gathers byte j of every stored row, row r landing in byte r
   always_comb begin
      rd_data = '0;
      for (int r = 0; r < BLK_N; r++) rd_data[r*PIX_W +: PIX_W] = mem[r][rd_col*PIX_W +: PIX_W];
   end
   // bank state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= BANK_EMPTY;
      else st <= st_nxt;
   // lifecycle: first row, last row, first column, last column
   always_comb begin
      st_nxt = st;
      case (st)
         BANK_EMPTY:    if (wr_en) st_nxt = (wr_row == LAST_IDX) ? BANK_FULL : BANK_FILLING;
         BANK_FILLING:  if (wr_en && wr_row == LAST_IDX) st_nxt = BANK_FULL;
         BANK_FULL:     if (rd_en) st_nxt = (rd_col == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
         BANK_DRAINING: if (rd_en && rd_col == LAST_IDX) st_nxt = BANK_EMPTY;
         default:       st_nxt = BANK_EMPTY;
      endcase
   end
   assign full = is_full(st);
endmodule

// File: rtl/transpose_buf.sv
// transpose_buf: 8x8 byte transpose between row and column 1-D stages; TRANSPOSE_PINGPONG_EN enables double buffering
module transpose_buf import dwt_pkg::*; (
   input logic           clk,
   input logic           rst_n,
   transpose_buf_if.slave bus
);
   logic [IDX_W-1:0] wr_row, rd_col;
   logic             wr_ptr, rd_ptr;
   logic             in_xfer, out_xfer;
   logic [1:0]       full;
   logic [ROW_W-1:0] rd_data [2];
   assign in_xfer      = bus.in_valid && bus.in_ready;
   assign out_xfer     = bus.out_valid && bus.out_ready;
   assign bus.in_ready  = !full[wr_ptr];
   assign bus.out_valid = full[rd_ptr];
   assign bus.out_data  = bus.out_valid ? rd_data[rd_ptr] : '0;
   assign bus.out_last  = bus.out_valid && (rd_col == LAST_IDX);
   for (genvar b = 0; b < 2; b++) begin : g_bank
      if (b < BANK_N) begin : g_inst
         transpose_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (in_xfer && (wr_ptr == 1'(b))),
            .wr_row  (wr_row),
            .wr_data (bus.in_data),
            .rd_en   (out_xfer && (rd_ptr == 1'(b))),
            .rd_col  (rd_col),
            .rd_data (rd_data[b]),
            .full    (full[b])
         );
      end else begin : g_tie
         assign full[b]    = 1'b0;
         assign rd_data[b] = '0;
      end
   end
   // row and column counters advance on their own handshakes and wrap 7->0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_row <= '0;
         rd_col <= '0;
      end else begin
         if (in_xfer) wr_row <= wr_row + IDX_W'(1);
         if (out_xfer) rd_col <= rd_col + IDX_W'(1);
      end
`ifdef TRANSPOSE_PINGPONG_EN
   // write and read sides swap banks independently as each block completes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (in_xfer && wr_row == LAST_IDX) wr_ptr <= !wr_ptr;
         if (out_xfer && rd_col == LAST_IDX) rd_ptr <= !rd_ptr;
      end
`else
   assign wr_ptr = 1'b0;
   assign rd_ptr = 1'b0;
`endif
   // a stalled column must be held unchanged until taken
   a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last));
endmodule

// File: tb/tb_transpose_buf.sv
// tb_transpose_buf: directed stimulus with a queue-based transpose model checked every cycle
module tb_transpose_buf;
   import dwt_pkg::*;
   localparam int NBK = BANK_N;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   transpose_buf_if bus();
   transpose_buf dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int stall_cnt = 0;
   int blocks;
   logic [63:0] rows[$];
   logic [63:0] expq[$];
   logic [63:0] got[$];
   logic        got_last[$];
   int          got_cyc[$];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic logic [63:0] const_row(input int r);
      logic [7:0] v = 8'(r + 1);
      return {8{v}};
   endfunction
   function automatic logic [63:0] ramp_row(input int r);
      logic [63:0] w = '0;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(8*r + k);
      return w;
   endfunction
   function automatic void add_block();
      for (int j = 0; j < 8; j++) begin
         logic [63:0] c = '0;
         for (int r = 0; r < 8; r++) c[8*r +: 8] = rows[r][8*j +: 8];
         expq.push_back(c);
      end
   endfunction
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
         chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
         chk("rst_out_last", 64'(bus.out_last), 64'd0);
         chk("rst_out_data", bus.out_data, 64'd0);
         rows.delete();
         expq.delete();
      end else begin
         blocks = (expq.size() + 7) / 8;
         chk("in_ready", 64'(bus.in_ready), 64'(blocks < NBK));
         chk("out_valid", 64'(bus.out_valid), 64'(expq.size() > 0));
         chk("out_data", bus.out_data, (expq.size() > 0) ? expq[0] : 64'd0);
         chk("out_last", 64'(bus.out_last), 64'(expq.size() % 8 == 1));
         if (bus.in_valid && !bus.in_ready) stall_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
            got_cyc.push_back(cyc);
            if (expq.size() > 0) void'(expq.pop_front());
         end
         if (bus.in_valid && bus.in_ready) begin
            rows.push_back(bus.in_data);
            if (rows.size() == 8) begin
               add_block();
               rows.delete();
            end
         end
      end
   end
   task automatic push(input logic [63:0] d);
      bit acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) chk("push_timeout", 64'd0, 64'd1);
   endtask
   task automatic wait_cols(input int n, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
         if (got.size() >= n) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) chk("col_timeout", 64'(got.size()), 64'(n));
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int base;
      bit ok;
      logic [63:0] sd;
      logic sv, sl;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      // constant rows: every column identical
      base = got.size();
      for (int r = 0; r < 8; r++) push(const_row(r));
      wait_cols(base + 8, ok);
      if (ok) begin
         for (int j = 0; j < 8; j++) chk("t1_col", got[base+j], 64'h0807060504030201);
         chk("t1_last_c0", 64'(got_last[base]), 64'd0);
         chk("t1_last_c7", 64'(got_last[base+7]), 64'd1);
      end
      // ramp rows: true transpose
      base = got.size();
      for (int r = 0; r < 8; r++) push(ramp_row(r));
      wait_cols(base + 8, ok);
      if (ok) begin
         chk("t2_col0", got[base], 64'h3830282018100800);
         chk("t2_col7", got[base+7], 64'h3f372f271f170f07);
      end
      // backpressure at column 3
      base = got.size();
      for (int r = 0; r < 8; r++) push(ramp_row(r));
      wait_cols(base + 3, ok);
      bus.out_ready = 1'b0;
      @(negedge clk);
      sd = bus.out_data;
      sv = bus.out_valid;
      sl = bus.out_last;
      chk("t3_stall_col3", sd, 64'h3b332b231b130b03);
      chk("t3_stall_valid", 64'(sv), 64'd1);
      repeat (5) begin
         @(negedge clk);
         chk("t3_hold_data", bus.out_data, sd);
         chk("t3_hold_valid", 64'(bus.out_valid), 64'(sv));
         chk("t3_hold_last", 64'(bus.out_last), 64'(sl));
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      wait_cols(base + 8, ok);
      if (ok) begin
         chk("t3_col3", got[base+3], 64'h3b332b231b130b03);
         chk("t3_col4", got[base+4], 64'h3c342c241c140c04);
      end
      // two back-to-back blocks
      stall_cnt = 0;
      base = got.size();
      for (int r = 0; r < 8; r++) push(const_row(r));
      for (int r = 0; r < 8; r++) push(ramp_row(r));
      wait_cols(base + 16, ok);
      chk("t4_in_stall", 64'(stall_cnt), (NBK == 2) ? 64'd0 : 64'd8);
      if (ok) begin
         chk("t4_span", 64'(got_cyc[base+15] - got_cyc[base]), (NBK == 2) ? 64'd15 : 64'd23);
         chk("t4_b0_col0", got[base], 64'h0807060504030201);
         chk("t4_b1_col0", got[base+8], 64'h3830282018100800);
         chk("t4_b1_last", 64'(got_last[base+15]), 64'd1);
      end
      // reset after a partial block discards it
      for (int r = 0; r < 5; r++) push(64'hffff_ffff_ffff_ffff);
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t5_post_valid", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      base = got.size();
      for (int r = 0; r < 8; r++) push(ramp_row(r));
      wait_cols(base + 8, ok);
      if (ok) begin
         chk("t5_col0", got[base], 64'h3830282018100800);
         chk("t5_col7", got[base+7], 64'h3f372f271f170f07);
      end
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
